ajuste_ctrl: RTL

Sequencing controller for the 60-bit to 18-bit window-select datapath in the fixed-point multiply chain. It accepts a 60-bit product over a valid/ready handshake and picks the window shift `s` (0..42) in one of two ways: a software-configured fixed shift, or automatic normalization that places the leading one at bit 17 of the result. It then presents the 18-bit result, the shift used and an overflow flag downstream over a second valid/ready handshake. It sits between the multiplier output stage and the next 18-bit consumer.

---
 rtl/ajuste_ctrl_if.sv | 25 ++
 rtl/ajuste_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/ajuste_ctrl_if.sv
// ajuste_ctrl_if: product/result handshake bundle for ajuste_ctrl.
//   in_valid/in_ready/r            : 60-bit product input handshake
//   out_valid/out_ready            : result output handshake
//   y/s_used/ovf                   : 18-bit window, shift applied, lost-bits flag
// master: product source + result consumer side. slave: the controller.
interface ajuste_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [59:0] r;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] y;
    logic [5:0]  s_used;
    logic        ovf;

    modport master (
        output in_valid, r, out_ready,
        input  in_ready, out_valid, y, s_used, ovf
    );

    modport slave (
        input  in_valid, r, out_ready,
        output in_ready, out_valid, y, s_used, ovf
    );
endinterface

// File: rtl/ajuste_ctrl.sv
// ajuste_ctrl: picks the 18-bit window r[s+17:s] out of a 60-bit product, either with a
// configured fixed shift or by normalizing the leading one to bit 17, and hands the result on.
//   clk, rst   : clock, synchronous active-high reset
//   cfg_we     : config strobe latching cfg_mode (0 fixed, 1 auto) and cfg_shift (clamped to 42)
//   bus        : product in / result out handshakes (ajuste_ctrl_if.slave)
//   busy       : high while a product is being scanned or its result is pending
module ajuste_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic         cfg_mode,
    input  logic [5:0]   cfg_shift,
    ajuste_ctrl_if.slave bus,
    output logic         busy
);

    typedef enum logic [1:0] {st_idle, st_scan, st_out} state_t;

    state_t      state_q, state_d;
    logic        mode_q;
    logic [5:0]  shift_q;
    logic        mode_c;   // mode captured with the product in flight
    logic [59:0] r_q;
    logic [5:0]  s_q;
    logic [5:0]  k_q;
    logic        capture;
    logic        scan_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        scan_done = 1'b0;
        unique case (state_q)
            st_idle: begin
                if (bus.in_valid) begin
                    capture = 1'b1;
                    state_d = mode_q ? st_scan : st_out;
                end
            end
            st_scan: begin
                // Window top bit at k+17; k==0 covers products with msb <= 17 (and zero).
                if (r_q[k_q + 6'd17] || (k_q == 6'd0)) begin
                    scan_done = 1'b1;
                    state_d   = st_out;
                end
            end
            st_out: begin
                if (bus.out_ready) begin
                    state_d = st_idle;
                end
            end
            default: state_d = st_idle;
        endcase
    end

    // Config writes land even while busy; capture samples the pre-write values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 1'b0;
            shift_q <= 6'd0;
            mode_c  <= 1'b0;
            r_q     <= 60'd0;
            s_q     <= 6'd0;
            k_q     <= 6'd0;
        end else begin
            if (cfg_we) begin
                mode_q  <= cfg_mode;
                shift_q <= (cfg_shift > 6'd42) ? 6'd42 : cfg_shift;
            end
            if (capture) begin
                r_q    <= bus.r;
                mode_c <= mode_q;
                s_q    <= mode_q ? 6'd0 : shift_q;
                k_q    <= 6'd42;
            end else if (state_q == st_scan) begin
                if (scan_done) begin
                    s_q <= k_q;
                end else begin
                    k_q <= k_q - 6'd1;
                end
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == st_idle) && !rst;
        bus.out_valid = (state_q == st_out);
        busy          = (state_q != st_idle);
        bus.y         = bus.out_valid ? 18'(r_q >> s_q) : 18'd0;
        bus.s_used    = bus.out_valid ? s_q : 6'd0;
        // Shifting by 60 (s=42) leaves nothing, so ovf is naturally 0 there.
        bus.ovf       = bus.out_valid && !mode_c && (|(r_q >> (7'(s_q) + 7'd18)));
    end

endmodule
